// File: rtl/hps_avm_arbiter_pkg.sv
// Shared types and widths for the two-requester Avalon-MM arbiter.
package hps_avm_arbiter_pkg;

    // Arbiter FSM encoding: waiting for a request, or serving the granted requester.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Requester id: 0 selects S0, 1 selects S1.
    localparam int unsigned ID_W = 1;
    typedef logic [ID_W-1:0] req_id_t;

    // Width of the saturating orphan-response counter.
    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/hps_id_fifo.sv
// Pending-read FIFO holding the requester id of every issued read, oldest at head.
module hps_id_fifo
    import hps_avm_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output req_id_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Entry storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hps_avm_arbiter.sv
// Round-robin, per-transaction arbiter of two Avalon-MM requesters onto one master port.
module hps_avm_arbiter
    import hps_avm_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 30,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_PEND = 4
) (
    input  logic                  csi_MCLK_clk,
    input  logic                  rsi_MRST_reset_n,
    input  logic [ADDR_W-1:0]     avs_S0_address,
    input  logic [DATA_W-1:0]     avs_S0_writedata,
    input  logic [DATA_W/8-1:0]   avs_S0_byteenable,
    input  logic                  avs_S0_read,
    input  logic                  avs_S0_write,
    output logic [DATA_W-1:0]     avs_S0_readdata,
    output logic                  avs_S0_readdatavalid,
    output logic                  avs_S0_waitrequest,
    input  logic [ADDR_W-1:0]     avs_S1_address,
    input  logic [DATA_W-1:0]     avs_S1_writedata,
    input  logic [DATA_W/8-1:0]   avs_S1_byteenable,
    input  logic                  avs_S1_read,
    input  logic                  avs_S1_write,
    output logic [DATA_W-1:0]     avs_S1_readdata,
    output logic                  avs_S1_readdatavalid,
    output logic                  avs_S1_waitrequest,
    output logic [ADDR_W-1:0]     avm_M1_address,
    output logic [DATA_W-1:0]     avm_M1_writedata,
    output logic [DATA_W/8-1:0]   avm_M1_byteenable,
    output logic                  avm_M1_read,
    output logic                  avm_M1_write,
    output logic                  avm_M1_begintransfer,
    input  logic [DATA_W-1:0]     avm_M1_readdata,
    input  logic                  avm_M1_readdatavalid,
    input  logic                  avm_M1_waitrequest,
    output logic                  coe_ERR_orphan,
    output logic [ERR_CNT_W-1:0]  coe_ERR_count
);

    arb_state_t           state;
    req_id_t              grant_id;
    req_id_t              last_id;
    req_id_t              pick_id;
    logic                 first;
    logic [1:0]           s_read;
    logic [1:0]           s_write;
    logic [1:0]           s_req;
    logic                 in_grant;
    logic                 g_read;
    logic                 g_write;
    logic                 blocked;
    logic                 issue;
    logic                 complete;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    req_id_t              fifo_head;
    logic                 orphan_hit;
    logic                 err_orphan;
    logic [ERR_CNT_W-1:0] err_count;

    assign s_read  = {avs_S1_read, avs_S0_read};
    assign s_write = {avs_S1_write, avs_S0_write};
    assign s_req   = s_read | s_write;

    // Round-robin choice: on a tie the requester not served last wins.
    always_comb begin
        pick_id = last_id;
        if (s_req[0] && s_req[1]) begin
            pick_id = ~last_id;
        end else if (s_req[1]) begin
            pick_id = 1'b1;
        end else begin
            pick_id = 1'b0;
        end
    end

    // Granted-requester qualifiers; a read stalls while every pending slot is taken.
    always_comb begin
        in_grant = (state == ST_GRANT);
        g_read   = s_read[grant_id];
        g_write  = s_write[grant_id];
        blocked  = in_grant && g_read && fifo_full;
        issue    = in_grant && (g_read || g_write) && !blocked;
        complete = issue && !avm_M1_waitrequest;
    end

    // Transaction FSM: latch a grant, flag the first issuing cycle, return to idle on completion or withdrawal.
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            state    <= ST_IDLE;
            grant_id <= 1'b0;
            last_id  <= 1'b1;
            first    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|s_req) begin
                        grant_id <= pick_id;
                        first    <= 1'b1;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (complete) begin
                        last_id <= grant_id;
                        first   <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (!(g_read || g_write)) begin
                        first <= 1'b0;
                        state <= ST_IDLE;
                    end else if (issue) begin
                        first <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Master-side mux and requester handshakes, following the granted requester.
    always_comb begin
        avm_M1_address       = (grant_id == 1'b1) ? avs_S1_address    : avs_S0_address;
        avm_M1_writedata     = (grant_id == 1'b1) ? avs_S1_writedata  : avs_S0_writedata;
        avm_M1_byteenable    = (grant_id == 1'b1) ? avs_S1_byteenable : avs_S0_byteenable;
        avm_M1_read          = issue && g_read;
        avm_M1_write         = issue && g_write;
        avm_M1_begintransfer = issue && first;
        avs_S0_waitrequest   = 1'b1;
        avs_S1_waitrequest   = 1'b1;
        if (in_grant && !blocked) begin
            if (grant_id == 1'b1) begin
                avs_S1_waitrequest = avm_M1_waitrequest;
            end else begin
                avs_S0_waitrequest = avm_M1_waitrequest;
            end
        end
    end

    // Response routing: readdata is broadcast, valid goes to the owner at the FIFO head.
    always_comb begin
        fifo_push            = complete && g_read;
        fifo_pop             = avm_M1_readdatavalid && !fifo_empty;
        orphan_hit           = avm_M1_readdatavalid && fifo_empty;
        avs_S0_readdata      = avm_M1_readdata;
        avs_S1_readdata      = avm_M1_readdata;
        avs_S0_readdatavalid = fifo_pop && (fifo_head == 1'b0);
        avs_S1_readdatavalid = fifo_pop && (fifo_head == 1'b1);
    end

    // Orphan response pulse and saturating count.
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            err_orphan <= 1'b0;
            err_count  <= '0;
        end else begin
            err_orphan <= orphan_hit;
            if (orphan_hit && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign coe_ERR_orphan = err_orphan;
    assign coe_ERR_count  = err_count;

    hps_id_fifo #(
        .DEPTH (MAX_PEND)
    ) u_id_fifo (
        .clk     (csi_MCLK_clk),
        .rst_n   (rsi_MRST_reset_n),
        .push    (fifo_push),
        .push_id (grant_id),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_hps_avm_arbiter.sv
// Scoreboard bench for hps_avm_arbiter: directed scenarios plus randomized two-requester traffic.
module tb_hps_avm_arbiter;

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned MAX_PEND = 4;
    localparam int unsigned LOW_W    = ADDR_W - 1;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst_n;
    logic [1:0][ADDR_W-1:0]     s_addr;
    logic [1:0][DATA_W-1:0]     s_wdata;
    logic [1:0][BE_W-1:0]       s_be;
    logic [1:0]                 s_rd;
    logic [1:0]                 s_wr;
    logic [DATA_W-1:0]          s0_rdata, s1_rdata;
    logic                       s0_rdv, s1_rdv, s0_wait, s1_wait;
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic [BE_W-1:0]            m_be;
    logic                       m_rd, m_wr, m_bt;
    logic [DATA_W-1:0]          m_rdata;
    logic                       m_rdv, m_wait;
    logic                       orphan;
    logic [7:0]                 err_cnt;

    int                total = 0;
    int                bad   = 0;
    int                bt_cnt = 0;
    logic              sb_en;
    logic              req_done;
    xfer_t             exp_xfer0[$];
    xfer_t             exp_xfer1[$];
    logic [DATA_W-1:0] exp_rd0[$];
    logic [DATA_W-1:0] exp_rd1[$];
    logic [DATA_W-1:0] rsp_q[$];
    int                grant_log[$];

    hps_avm_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset_n     (rst_n),
        .avs_S0_address       (s_addr[0]),
        .avs_S0_writedata     (s_wdata[0]),
        .avs_S0_byteenable    (s_be[0]),
        .avs_S0_read          (s_rd[0]),
        .avs_S0_write         (s_wr[0]),
        .avs_S0_readdata      (s0_rdata),
        .avs_S0_readdatavalid (s0_rdv),
        .avs_S0_waitrequest   (s0_wait),
        .avs_S1_address       (s_addr[1]),
        .avs_S1_writedata     (s_wdata[1]),
        .avs_S1_byteenable    (s_be[1]),
        .avs_S1_read          (s_rd[1]),
        .avs_S1_write         (s_wr[1]),
        .avs_S1_readdata      (s1_rdata),
        .avs_S1_readdatavalid (s1_rdv),
        .avs_S1_waitrequest   (s1_wait),
        .avm_M1_address       (m_addr),
        .avm_M1_writedata     (m_wdata),
        .avm_M1_byteenable    (m_be),
        .avm_M1_read          (m_rd),
        .avm_M1_write         (m_wr),
        .avm_M1_begintransfer (m_bt),
        .avm_M1_readdata      (m_rdata),
        .avm_M1_readdatavalid (m_rdv),
        .avm_M1_waitrequest   (m_wait),
        .coe_ERR_orphan       (orphan),
        .coe_ERR_count        (err_cnt)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk(name, 96'(act), 96'(exp));
    endtask

    // Memory model of the slave: read data is a fixed function of the address.
    function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
        return {~a[15:0], a[15:0]} + DATA_W'(a[ADDR_W-1:16]);
    endfunction

    function automatic logic wait_of(input int n);
        return (n == 0) ? s0_wait : s1_wait;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_q();
        exp_xfer0.delete();
        exp_xfer1.delete();
        exp_rd0.delete();
        exp_rd1.delete();
        grant_log.delete();
    endtask

    // One requester transaction: record expectations, hold the request until accepted.
    task automatic do_xfer(input int n, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be,
                           input logic [DATA_W-1:0] exp_data);
        xfer_t x;
        int    cyc;
        x = '{wr: wr, addr: addr, data: data, be: be};
        if (n == 0) begin
            exp_xfer0.push_back(x);
            if (!wr) exp_rd0.push_back(exp_data);
        end else begin
            exp_xfer1.push_back(x);
            if (!wr) exp_rd1.push_back(exp_data);
        end
        s_addr[n]  = addr;
        s_wdata[n] = data;
        s_be[n]    = be;
        s_rd[n]    = !wr;
        s_wr[n]    = wr;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (wait_of(n) && cyc < 5000);
        if (cyc >= 5000) chk_bit($sformatf("req%0d_timeout", n), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        s_rd[n] = 1'b0;
        s_wr[n] = 1'b0;
    endtask

    task automatic rand_req(input int n, input int cnt);
        logic [ADDR_W-1:0] a;
        logic              wr;
        for (int k = 0; k < cnt; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            a  = {1'(n), LOW_W'($urandom)};
            wr = 1'($urandom_range(0, 1));
            do_xfer(n, wr, a, $urandom, BE_W'($urandom), rd_model(a));
        end
    endtask

    // Slave model: random waitrequest, in-order read responses with random latency.
    task automatic slave_run(input int wait_pct, input int rsp_pct, input logic seq_data);
        int seq;
        int cyc;
        seq = 0;
        cyc = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            if (m_rd && !m_wait) begin
                seq++;
                rsp_q.push_back(seq_data ? DATA_W'(32'h11 * seq) : rd_model(m_addr));
            end
            if (req_done && rsp_q.size() == 0) break;
            tick();
            cyc++;
            m_wait = ($urandom_range(0, 99) < wait_pct);
            m_rdv  = 1'b0;
            m_rdata = $urandom;
            if (rsp_q.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
                m_rdv   = 1'b1;
                m_rdata = rsp_q.pop_front();
            end
        end
        if (cyc >= 20000) chk_bit("slave_timeout", 1'b1, 1'b0);
        tick();
        m_rdv  = 1'b0;
        m_wait = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a master transfer or a response.
    always @(negedge clk) begin
        xfer_t got;
        xfer_t want;
        if (!sb_en) begin
            bt_cnt = 0;
        end else begin
            if (m_bt) bt_cnt++;
            if ((m_rd || m_wr) && !m_wait) begin
                got = '{wr: m_wr, addr: m_addr, data: (m_wr ? m_wdata : '0), be: m_be};
                grant_log.push_back(int'(m_addr[ADDR_W-1]));
                want = '0;
                if (m_addr[ADDR_W-1] == 1'b0 && exp_xfer0.size() > 0) begin
                    want = exp_xfer0.pop_front();
                end else if (m_addr[ADDR_W-1] == 1'b1 && exp_xfer1.size() > 0) begin
                    want = exp_xfer1.pop_front();
                end else begin
                    chk_bit("xfer_unexpected", 1'b1, 1'b0);
                end
                if (!want.wr) want.data = '0;
                chk("xfer", 96'(got), 96'(want));
                chk("begintransfer_per_xfer", 96'(bt_cnt), 96'(1));
                bt_cnt = 0;
            end
            if (s0_rdv) begin
                if (exp_rd0.size() == 0) chk_bit("s0_rdv_unexpected", 1'b1, 1'b0);
                else chk("s0_readdata", 96'(s0_rdata), 96'(exp_rd0.pop_front()));
            end
            if (s1_rdv) begin
                if (exp_rd1.size() == 0) chk_bit("s1_rdv_unexpected", 1'b1, 1'b0);
                else chk("s1_readdata", 96'(s1_rdata), 96'(exp_rd1.pop_front()));
            end
            if (m_rdv) chk("rdv_one_owner", 96'(int'(s0_rdv) + int'(s1_rdv)), 96'(1));
        end
    end

    initial begin
        rst_n = 1'b0; sb_en = 1'b0; req_done = 1'b0;
        s_addr = '0; s_wdata = '0; s_be = '0; s_rd = '0; s_wr = '0;
        m_rdata = '0; m_rdv = 1'b0; m_wait = 1'b0;
        repeat (3) tick();

        // Values held during reset
        @(negedge clk);
        chk_bit("rst_m_read", m_rd, 1'b0);
        chk_bit("rst_m_write", m_wr, 1'b0);
        chk_bit("rst_m_bt", m_bt, 1'b0);
        chk_bit("rst_s0_wait", s0_wait, 1'b1);
        chk_bit("rst_s1_wait", s1_wait, 1'b1);
        chk_bit("rst_s0_rdv", s0_rdv, 1'b0);
        chk_bit("rst_orphan", orphan, 1'b0);
        chk("rst_err_count", 96'(err_cnt), 96'(0));
        tick();
        rst_n = 1'b1;

        // Single S0 write, zero wait states
        s_wr[0] = 1'b1; s_addr[0] = 30'h100; s_wdata[0] = 32'hDEADBEEF; s_be[0] = 4'hF;
        @(negedge clk);
        chk_bit("w_idle_write", m_wr, 1'b0);
        chk_bit("w_idle_s0_wait", s0_wait, 1'b1);
        tick();
        @(negedge clk);
        chk_bit("w_write", m_wr, 1'b1);
        chk("w_addr", 96'(m_addr), 96'(30'h100));
        chk("w_data", 96'(m_wdata), 96'(32'hDEADBEEF));
        chk("w_be", 96'(m_be), 96'(4'hF));
        chk_bit("w_bt", m_bt, 1'b1);
        chk_bit("w_s0_wait", s0_wait, 1'b0);
        chk_bit("w_s1_wait", s1_wait, 1'b1);
        tick();
        s_wr[0] = 1'b0;
        @(negedge clk);
        chk_bit("w_after_write", m_wr, 1'b0);
        chk_bit("w_after_bt", m_bt, 1'b0);
        chk_bit("w_after_s0_wait", s0_wait, 1'b1);

        // Orphan responses and counter saturation
        tick();
        m_rdv = 1'b1; m_rdata = 32'h77;
        @(negedge clk);
        chk_bit("orph_s0_rdv", s0_rdv, 1'b0);
        chk_bit("orph_s1_rdv", s1_rdv, 1'b0);
        chk_bit("orph_pulse_early", orphan, 1'b0);
        tick();
        m_rdv = 1'b0;
        @(negedge clk);
        chk_bit("orph_pulse", orphan, 1'b1);
        chk("orph_count1", 96'(err_cnt), 96'(1));
        tick();
        @(negedge clk);
        chk_bit("orph_pulse_end", orphan, 1'b0);
        tick();
        m_rdv = 1'b1;
        repeat (299) tick();
        m_rdv = 1'b0;
        @(negedge clk);
        chk("orph_saturate", 96'(err_cnt), 96'(255));
        tick();
        do_reset();
        @(negedge clk);
        chk("orph_cleared", 96'(err_cnt), 96'(0));
        tick();

        // Both requesters reading together: alternating grants and routing
        clear_q();
        sb_en = 1'b1; req_done = 1'b0;
        fork
            begin
                fork
                    for (int k = 0; k < 3; k++)
                        do_xfer(0, 1'b0, {1'b0, LOW_W'(k)}, '0, 4'hF, DATA_W'(32'h11 * (2 * k + 1)));
                    for (int k = 0; k < 3; k++)
                        do_xfer(1, 1'b0, {1'b1, LOW_W'(k)}, '0, 4'hF, DATA_W'(32'h11 * (2 * k + 2)));
                join
                req_done = 1'b1;
            end
            slave_run(0, 50, 1'b1);
        join
        sb_en = 1'b0;
        chk("rr_count", 96'(grant_log.size()), 96'(6));
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk($sformatf("rr_order%0d", k), 96'(grant_log[k]), 96'(k % 2));
        chk("rr_rd_drain", 96'(exp_rd0.size() + exp_rd1.size()), 96'(0));

        // Pending limit: fifth read held until a slot frees
        clear_q();
        for (int k = 0; k < 4; k++) do_xfer(1, 1'b0, 30'h20 + 30'(k), '0, 4'hF, '0);
        s_rd[1] = 1'b1; s_addr[1] = 30'h30;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_bit($sformatf("blk_read%0d", k), m_rd, 1'b0);
            chk_bit($sformatf("blk_wait%0d", k), s1_wait, 1'b1);
            tick();
        end
        m_rdv = 1'b1; m_rdata = 32'hAB;
        @(negedge clk);
        chk_bit("blk_still_held", m_rd, 1'b0);
        chk_bit("blk_s1_rdv", s1_rdv, 1'b1);
        chk_bit("blk_s0_rdv", s0_rdv, 1'b0);
        chk("blk_s1_rdata", 96'(s1_rdata), 96'(32'hAB));
        tick();
        m_rdv = 1'b0;
        @(negedge clk);
        chk_bit("blk_issue_read", m_rd, 1'b1);
        chk_bit("blk_issue_bt", m_bt, 1'b1);
        chk_bit("blk_issue_wait", s1_wait, 1'b0);
        tick();
        s_rd[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_rdv = 1'b1;
            @(negedge clk);
            chk_bit($sformatf("blk_drain%0d", k), s1_rdv, 1'b1);
            tick();
        end
        m_rdv = 1'b0;
        @(negedge clk);
        chk("blk_no_orphans", 96'(err_cnt), 96'(0));
        tick();

        // Write behind an outstanding read, with three wait cycles
        clear_q();
        do_xfer(0, 1'b0, 30'h5, '0, 4'hF, '0);
        m_wait = 1'b1;
        s_wr[1] = 1'b1; s_addr[1] = 30'h200; s_wdata[1] = 32'h12345678; s_be[1] = 4'h3;
        @(negedge clk);
        chk_bit("ww_idle", m_wr, 1'b0);
        tick();
        @(negedge clk);
        chk_bit("ww_write1", m_wr, 1'b1);
        chk_bit("ww_bt1", m_bt, 1'b1);
        chk_bit("ww_wait1", s1_wait, 1'b1);
        tick();
        @(negedge clk);
        chk_bit("ww_bt2", m_bt, 1'b0);
        chk_bit("ww_wait2", s1_wait, 1'b1);
        tick();
        @(negedge clk);
        chk_bit("ww_wait3", s1_wait, 1'b1);
        tick();
        m_wait = 1'b0;
        @(negedge clk);
        chk_bit("ww_done_wait", s1_wait, 1'b0);
        chk_bit("ww_done_write", m_wr, 1'b1);
        chk("ww_done_addr", 96'(m_addr), 96'(30'h200));
        tick();
        s_wr[1] = 1'b0; m_rdv = 1'b1; m_rdata = 32'hCAFE;
        @(negedge clk);
        chk_bit("ww_s0_rdv", s0_rdv, 1'b1);
        chk_bit("ww_s1_rdv", s1_rdv, 1'b0);
        chk("ww_s0_rdata", 96'(s0_rdata), 96'(32'hCAFE));
        chk("ww_s1_bcast", 96'(s1_rdata), 96'(32'hCAFE));
        tick();
        m_rdv = 1'b0;

        // Reset in the middle of a grant with two reads pending
        do_xfer(0, 1'b0, 30'h40, '0, 4'hF, '0);
        do_xfer(1, 1'b0, 30'h41, '0, 4'hF, '0);
        m_wait = 1'b1; s_rd[0] = 1'b1; s_addr[0] = 30'h42;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk_bit("mr_in_grant", m_rd, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; s_rd[0] = 1'b0; m_wait = 1'b0;
        @(negedge clk);
        chk_bit("mr_read", m_rd, 1'b0);
        chk_bit("mr_bt", m_bt, 1'b0);
        chk_bit("mr_s0_wait", s0_wait, 1'b1);
        chk_bit("mr_s1_wait", s1_wait, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            m_rdv = 1'b1;
            @(negedge clk);
            chk_bit($sformatf("mr_late_s0_%0d", k), s0_rdv, 1'b0);
            chk_bit($sformatf("mr_late_s1_%0d", k), s1_rdv, 1'b0);
        end
        tick();
        m_rdv = 1'b0;
        @(negedge clk);
        chk("mr_orphans", 96'(err_cnt), 96'(2));
        tick();
        clear_q();
        do_reset();

        // Randomized traffic from both requesters against the slave model
        sb_en = 1'b1; req_done = 1'b0;
        fork
            begin
                fork
                    rand_req(0, 60);
                    rand_req(1, 60);
                join
                req_done = 1'b1;
            end
            slave_run(25, 20, 1'b0);
        join
        tick();
        sb_en = 1'b0;
        chk("rand_xfer_drain", 96'(exp_xfer0.size() + exp_xfer1.size()), 96'(0));
        chk("rand_rd_drain", 96'(exp_rd0.size() + exp_rd1.size()), 96'(0));
        chk("rand_no_orphans", 96'(err_cnt), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
